// File: rtl/shift_register_n.sv
// WIDTH-bit capture/serialiser register: sync reset/set, clock enable, parallel load,
// left/right serial shift, and a per-word shift counter with a one-cycle done pulse.
module shift_register_n #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VALUE   = {WIDTH{1'b1}},
  localparam int unsigned     CW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             ce,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic [CW-1:0]    shift_count,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_e;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= RESET_VALUE;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;
    if (set) begin
      q_d    = SET_VALUE;
      sout_d = 1'b0;
      cnt_d  = '0;
    end else if (ce) begin
      case (mode_e'(mode))
        MODE_LOAD: begin
          q_d   = D;
          cnt_d = '0;
        end
        // Concatenate-then-truncate keeps the WIDTH=1 case legal: Q simply becomes sin.
        MODE_SHL: begin
          q_d    = WIDTH'({q_q, sin});
          sout_d = q_q[WIDTH-1];
          shift  = 1'b1;
        end
        MODE_SHR: begin
          q_d    = WIDTH'({sin, q_q} >> 1);
          sout_d = q_q[0];
          shift  = 1'b1;
        end
        default: ;
      endcase
    end
    // Direction changes mid-word deliberately leave the count alone.
    if (shift) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign Q           = q_q;
  assign sout        = sout_q;
  assign shift_count = cnt_q;
  assign done        = done_q;

endmodule

// File: tb/tb_shift_register_n.sv
// Bench for shift_register_n: directed vector table, random run against an
// arithmetic reference model (WIDTH=8), and a short WIDTH=1 sequence.
module tb_shift_register_n;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, set8, ce8, sin8;
  logic [1:0] mode8;
  logic [7:0] d8, q8;
  logic       sout8, done8;
  logic [2:0] cnt8;

  logic       rst1, set1, ce1, sin1;
  logic [1:0] mode1;
  logic [0:0] d1, q1;
  logic       sout1, done1;
  logic [0:0] cnt1;

  shift_register_n #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .set(set8), .ce(ce8), .mode(mode8), .D(d8), .sin(sin8),
    .Q(q8), .sout(sout8), .shift_count(cnt8), .done(done8)
  );

  shift_register_n #(.WIDTH(1)) u1 (
    .clk(clk), .reset(rst1), .set(set1), .ce(ce1), .mode(mode1), .D(d1), .sin(sin1),
    .Q(q1), .sout(sout1), .shift_count(cnt1), .done(done1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       r, s, c;
    logic [1:0] m;
    logic [7:0] d;
    logic       si;
    logic [7:0] eq;
    logic       es;
    logic [2:0] ec;
    logic       ed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic c, input logic [1:0] m,
                     input logic [7:0] d, input logic si, input logic [7:0] eq,
                     input logic es, input logic [2:0] ec, input logic ed);
    vec_t v;
    v.r = r; v.s = s; v.c = c; v.m = m; v.d = d; v.si = si;
    v.eq = eq; v.es = es; v.ec = ec; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic drive8(input logic r, input logic s, input logic c, input logic [1:0] m,
                        input logic [7:0] d, input logic si);
    rst8 = r; set8 = s; ce8 = c; mode8 = m; d8 = d; sin8 = si;
    @(posedge clk);
    #1;
  endtask

  // Reference model: state as plain integers, word position tracked modulo WIDTH.
  int unsigned m_q, m_sout, m_pos, m_done;

  task automatic model_step(input logic r, input logic s, input logic c, input logic [1:0] m,
                            input logic [7:0] d, input logic si);
    m_done = 0;
    if (r) begin
      m_q = 0; m_sout = 0; m_pos = 0;
    end else if (s) begin
      m_q = 255; m_sout = 0; m_pos = 0;
    end else if (c && m == 2'd1) begin
      m_q = d; m_pos = 0;
    end else if (c && m[1]) begin
      if (m == 2'd2) begin
        m_sout = (m_q >> 7) & 1;
        m_q    = ((m_q * 2) + si) % 256;
      end else begin
        m_sout = m_q % 2;
        m_q    = (m_q / 2) + (si ? 128 : 0);
      end
      m_pos  = (m_pos + 1) % 8;
      m_done = (m_pos == 0) ? 1 : 0;
    end
  endtask

  initial begin
    rst8 = 1'b1; set8 = 1'b0; ce8 = 1'b0; mode8 = 2'd0; d8 = '0; sin8 = 1'b0;
    rst1 = 1'b1; set1 = 1'b0; ce1 = 1'b0; mode1 = 2'd0; d1 = '0; sin1 = 1'b0;

    // reset, set, reset+set
    add(1,0,0,2'd0,8'h00,0, 8'h00,0,3'd0,0);
    add(0,1,0,2'd0,8'h00,0, 8'hFF,0,3'd0,0);
    add(1,1,1,2'd2,8'h00,1, 8'h00,0,3'd0,0);
    // load and hold
    add(0,0,1,2'd1,8'hA5,0, 8'hA5,0,3'd0,0);
    add(0,0,1,2'd0,8'h00,1, 8'hA5,0,3'd0,0);
    add(0,0,1,2'd0,8'h00,1, 8'hA5,0,3'd0,0);
    add(0,0,1,2'd0,8'h00,1, 8'hA5,0,3'd0,0);
    add(0,0,0,2'd2,8'h00,1, 8'hA5,0,3'd0,0);
    // shift left a full word, sin=1
    add(0,0,1,2'd2,8'h00,1, 8'h4B,1,3'd1,0);
    add(0,0,1,2'd2,8'h00,1, 8'h97,0,3'd2,0);
    add(0,0,1,2'd2,8'h00,1, 8'h2F,1,3'd3,0);
    add(0,0,1,2'd2,8'h00,1, 8'h5F,0,3'd4,0);
    add(0,0,1,2'd2,8'h00,1, 8'hBF,0,3'd5,0);
    add(0,0,1,2'd2,8'h00,1, 8'h7F,1,3'd6,0);
    add(0,0,1,2'd2,8'h00,1, 8'hFF,0,3'd7,0);
    add(0,0,1,2'd2,8'h00,1, 8'hFF,1,3'd0,1);
    add(0,0,1,2'd0,8'h00,1, 8'hFF,1,3'd0,0);
    // shift right with a ce gap
    add(0,0,1,2'd1,8'h81,0, 8'h81,1,3'd0,0);
    add(0,0,1,2'd3,8'h00,0, 8'h40,1,3'd1,0);
    add(0,0,1,2'd3,8'h00,0, 8'h20,0,3'd2,0);
    add(0,0,1,2'd3,8'h00,0, 8'h10,0,3'd3,0);
    add(0,0,1,2'd3,8'h00,0, 8'h08,0,3'd4,0);
    add(0,0,0,2'd3,8'h00,0, 8'h08,0,3'd4,0);
    add(0,0,0,2'd3,8'h00,0, 8'h08,0,3'd4,0);
    add(0,0,1,2'd3,8'h00,0, 8'h04,0,3'd5,0);
    add(0,0,1,2'd3,8'h00,0, 8'h02,0,3'd6,0);
    add(0,0,1,2'd3,8'h00,0, 8'h01,0,3'd7,0);
    add(0,0,1,2'd3,8'h00,0, 8'h00,1,3'd0,1);
    // abort mid-word with set, then a full word, then load right after the last shift
    for (int i = 1; i <= 5; i++) add(0,0,1,2'd2,8'h00,0, 8'h00,0,3'(i),0);
    add(0,1,1,2'd2,8'h00,0, 8'hFF,0,3'd0,0);
    add(0,0,1,2'd2,8'h00,0, 8'hFE,1,3'd1,0);
    add(0,0,1,2'd2,8'h00,0, 8'hFC,1,3'd2,0);
    add(0,0,1,2'd2,8'h00,0, 8'hF8,1,3'd3,0);
    add(0,0,1,2'd2,8'h00,0, 8'hF0,1,3'd4,0);
    add(0,0,1,2'd2,8'h00,0, 8'hE0,1,3'd5,0);
    add(0,0,1,2'd2,8'h00,0, 8'hC0,1,3'd6,0);
    add(0,0,1,2'd2,8'h00,0, 8'h80,1,3'd7,0);
    add(0,0,1,2'd2,8'h00,0, 8'h00,1,3'd0,1);
    add(0,0,1,2'd1,8'h3C,0, 8'h3C,1,3'd0,0);

    foreach (tbl[i]) begin
      drive8(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].m, tbl[i].d, tbl[i].si);
      check($sformatf("vec%0d.Q", i),    64'(q8),    64'(tbl[i].eq));
      check($sformatf("vec%0d.sout", i), 64'(sout8), 64'(tbl[i].es));
      check($sformatf("vec%0d.cnt", i),  64'(cnt8),  64'(tbl[i].ec));
      check($sformatf("vec%0d.done", i), 64'(done8), 64'(tbl[i].ed));
    end

    // randomized run against the model
    m_q = 0; m_sout = 0; m_pos = 0; m_done = 0;
    drive8(1,0,0,2'd0,8'h00,0);
    for (int n = 0; n < 600; n++) begin
      logic r, s, c, si;
      logic [1:0] m;
      logic [7:0] d;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 29) == 0);
      c  = ($urandom_range(0, 4) != 0);
      m  = 2'($urandom_range(0, 9) < 2 ? $urandom_range(0, 1) : $urandom_range(2, 3));
      d  = 8'($urandom);
      si = 1'($urandom);
      model_step(r, s, c, m, d, si);
      drive8(r, s, c, m, d, si);
      check("rnd.Q",    64'(q8),    64'(m_q));
      check("rnd.sout", 64'(sout8), 64'(m_sout));
      check("rnd.cnt",  64'(cnt8),  64'(m_pos));
      check("rnd.done", 64'(done8), 64'(m_done));
    end

    // WIDTH=1: every shift completes a word
    rst1 = 1'b1;
    @(posedge clk); #1;
    check("w1.reset.Q", 64'(q1), 64'd0);
    check("w1.reset.done", 64'(done1), 64'd0);
    rst1 = 1'b0; ce1 = 1'b1; mode1 = 2'd2;
    begin
      logic [2:0] pat;
      logic       prev;
      pat  = 3'b101;
      prev = 1'b0;
      for (int i = 2; i >= 0; i--) begin
        sin1 = pat[i];
        @(posedge clk); #1;
        check("w1.Q",    64'(q1),    64'(pat[i]));
        check("w1.sout", 64'(sout1), 64'(prev));
        check("w1.done", 64'(done1), 64'd1);
        check("w1.cnt",  64'(cnt1),  64'd0);
        prev = pat[i];
      end
    end
    mode1 = 2'd0;
    @(posedge clk); #1;
    check("w1.hold.done", 64'(done1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
